waterfall_display: RTL and testbench
====================================

Name: waterfall_display

Overview:
- Parametrised spectrogram (waterfall) renderer on the HDMI pixel clock.
- Takes screen coordinates and syncs from the display timing generator, and issues FFT-RAM bank/address reads.
- Maps returned magnitudes through a selectable colormap and outputs RGB with syncs delayed to match.
- Replaces the fixed 2-bank, 50-row, red-only renderer with configurable geometry, scaling, read latency and colour modes.
- Latches the oldest FFT index once per frame, so an FFT update mid-frame cannot tear the image.

Parameters:
- DATA_WIDTH, 4, magnitude width from RAM (1..8).
- COORDW, 16, width of sx/sy.
- FFT_BINS, 256, bins per FFT row (power of two).
- NO_FFTS, 50, FFT rows held in RAM (history depth).
- NO_BANKS, 2, RAM banks (power of two); FFT slot s lives in bank s mod NO_BANKS.
- RAM_ADDR_WIDTH, 12, per-bank address width.
- H_BIAS, 64, first drawn column.
- V_BIAS, 40, first drawn row.
- H_SCALE_LOG2, 1, screen columns per bin = 2^H_SCALE_LOG2.
- V_SCALE, 8, screen rows per FFT row (1..255, need not be a power of two).
- RD_LATENCY, 1, cycles from addr_rd/bank_rd registered to data_rd valid (1..4).
- BG_RGB, 24'h00002D, colour outside the draw box.

Ports:
- hdmi_clk  in  1  pixel clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- sx  in  COORDW  current pixel column.
- sy  in  COORDW  current pixel row.
- hve_in  in  3  {hsync, vsync, de} aligned with sx/sy.
- oldest_fft_idx  in  $clog2(NO_FFTS)  slot of the oldest stored FFT.
- cmap_mode  in  2  colormap select: 0 red, 1 gray, 2 heat, 3 gray.
- data_rd  in  DATA_WIDTH  magnitude read from RAM.
- bank_rd  out  NO_BANKS  one-hot bank read enable.
- addr_rd  out  RAM_ADDR_WIDTH  per-bank read address.
- rgb  out  24  pixel colour {R,G,B}.
- hve  out  3  hve_in delayed by PIPE_LAT = RD_LATENCY+2.

Behaviour:
- Reset (asynchronous, reset_n=0): rgb=0, hve=0, bank_rd=0, addr_rd=0, latched index=0, row counters=0, all delay-line stages=0. Reset asserted mid-frame clears everything immediately; after release, drawing resumes from the next frame start.
- Draw box:
  - W = FFT_BINS<<H_SCALE_LOG2, H = NO_FFTS*V_SCALE.
  - inside = (H_BIAS <= sx < H_BIAS+W) and (V_BIAS <= sy < V_BIAS+H).
- Frame latch: on the cycle where sx==0 and sy==0, oldest_fft_idx is captured into idx_q. idx_q is constant for the rest of the frame.
- Row tracking (no divider):
  - Counters row_idx and sub_row update only on cycles with sx==0.
  - sy==V_BIAS: row_idx=0, sub_row=0.
  - V_BIAS < sy < V_BIAS+H: sub_row increments; when it reaches V_SCALE-1 it wraps to 0 and row_idx increments.
  - All other rows: counters hold.
- Slot mapping: row 0 (top) shows the newest FFT.
  - slot = (idx_q + NO_FFTS - 1 - row_idx) mod NO_FFTS, computed without overflow; the wrap is handled by a conditional subtract.
  - bin = (sx - H_BIAS) >> H_SCALE_LOG2.
- Stage 1 (registered, 1 cycle):
  - Inside the box: bank_rd = one-hot(slot mod NO_BANKS); addr_rd = (slot / NO_BANKS)*FFT_BINS + bin, truncated to RAM_ADDR_WIDTH.
  - Outside the box: bank_rd=0; addr_rd holds its previous value.
- Delay lines:
  - inside is delayed by 1+RD_LATENCY cycles, so it is aligned with data_rd.
  - hve_in is delayed by PIPE_LAT cycles and driven out as hve.
- Colour stage (registered, 1 cycle):
  - v8 = data_rd bit-replicated MSB-first to 8 bits (e.g. DATA_WIDTH=4, 4'hA -> 8'hAA).
  - mode 0: rgb = {v8, 0, 0}.
  - mode 1 or 3: rgb = {v8, v8, v8}.
  - mode 2, v8 < 128: rgb = {2v8, 0, 255-2v8}.
  - mode 2, v8 >= 128: rgb = {255, 2(v8-128), 0}.
  - Delayed inside=0: rgb = BG_RGB.
  - Delayed de=0: rgb = 0. This takes priority over the other cases.
- Total latency from sx/sy to rgb/hve is PIPE_LAT, fixed. cmap_mode is sampled in the colour stage, so a mid-frame change takes effect from the next pixel out.
- oldest_fft_idx >= NO_FFTS is illegal input; the output is unspecified, but no X propagates past reset.

Optional Feature:
- Macro: WATERFALL_BORDER_EN.
- Defined: pixels in the 1-pixel ring just outside the draw box are drawn white (24'hFFFFFF). The ring covers the columns H_BIAS-1 and H_BIAS+W and the rows V_BIAS-1 and V_BIAS+H, each bounded to the box extent plus one pixel. The border flag uses the same delay as inside. de=0 still forces black.
- Undefined: no border logic is synthesised; the ring shows BG_RGB.

Test Plan:
- Reset: hold reset_n=0 with hve_in toggling -> rgb=0, hve=0, bank_rd=0. Release reset -> hve follows hve_in after exactly 3 cycles (RD_LATENCY=1).
- Addressing with defaults and oldest_fft_idx=10:
  - sx=64, sy=40 -> slot 9, bank_rd=2'b10, addr_rd=4*256+0=1024, one cycle later.
  - sx=575, sy=40 -> bin 255, addr_rd=1279.
- Row wrap with idx_q=0, V_SCALE=8:
  - sy=40..47 -> slot 49, bank 2'b10, addr 24*256=6144 truncated to 12 bits = 2048.
  - sy=48 -> slot 48, bank 2'b01.
  - sy=439 -> slot 0.
  - sy=440 -> BG_RGB.
- Frame latch: change oldest_fft_idx from 10 to 11 at sy=200 -> slot mapping is unchanged until the next sx=0/sy=0, then shifts by one.
- Colormap with data_rd=4'hA, inside, de=1:
  - mode 0 -> 24'hAA0000.
  - mode 1 -> 24'hAAAAAA.
  - mode 2 -> 24'hFF5400.
  - With data_rd=4'h3, mode 2 -> v8=33h -> 24'h660099.
- Latency sweep with RD_LATENCY=3 and WATERFALL_BORDER_EN defined:
  - rgb/hve lag inputs by 5 cycles.
  - sx=63, sy=100 -> rgb=24'hFFFFFF.
  - Same pixel with the macro undefined -> 24'h00002D.

Source files
------------

// File: rtl/waterfall_display.sv
// rtl/waterfall_display.sv - spectrogram (waterfall) renderer on the HDMI pixel clock
//
// Purpose:
//   Draws stored FFT rows as a scrolling spectrogram. The newest FFT is at the top row.
//   Screen coordinates are mapped to an FFT-RAM bank/address. The returned magnitude
//   goes through a selectable colormap. Syncs are delayed so they stay aligned with rgb.
//   The oldest-FFT slot is latched once per frame, at sx==0 and sy==0. Drawing begins
//   at the first frame start after reset.
//
// Ports:
//   hdmi_clk       pixel clock (only clock)
//   reset_n        asynchronous active-low reset
//   sx, sy         current pixel column / row
//   hve_in         {hsync, vsync, de} aligned with sx/sy
//   oldest_fft_idx slot of the oldest stored FFT
//   cmap_mode      0 red, 1 gray, 2 heat, 3 gray
//   data_rd        magnitude returned by the FFT RAM
//   bank_rd        one-hot bank read enable
//   addr_rd        per-bank read address
//   rgb            pixel colour {R,G,B}
//   hve            hve_in delayed by RD_LATENCY+2 cycles
//
// Optional build macro: WATERFALL_BORDER_EN draws a white 1-pixel ring around the box.
module waterfall_display #(
  parameter int          DATA_WIDTH     = 4,
  parameter int          COORDW         = 16,
  parameter int          FFT_BINS       = 256,
  parameter int          NO_FFTS        = 50,
  parameter int          NO_BANKS       = 2,
  parameter int          RAM_ADDR_WIDTH = 12,
  parameter int          H_BIAS         = 64,
  parameter int          V_BIAS         = 40,
  parameter int          H_SCALE_LOG2   = 1,
  parameter int          V_SCALE        = 8,
  parameter int          RD_LATENCY     = 1,
  parameter logic [23:0] BG_RGB         = 24'h00002D
) (
  input  logic                         hdmi_clk,
  input  logic                         reset_n,
  input  logic [COORDW-1:0]            sx,
  input  logic [COORDW-1:0]            sy,
  input  logic [2:0]                   hve_in,
  input  logic [$clog2(NO_FFTS)-1:0]   oldest_fft_idx,
  input  logic [1:0]                   cmap_mode,
  input  logic [DATA_WIDTH-1:0]        data_rd,
  output logic [NO_BANKS-1:0]          bank_rd,
  output logic [RAM_ADDR_WIDTH-1:0]    addr_rd,
  output logic [23:0]                  rgb,
  output logic [2:0]                   hve
);

  localparam int IDXW     = $clog2(NO_FFTS);
  localparam int BOX_W    = FFT_BINS << H_SCALE_LOG2;
  localparam int BOX_H    = NO_FFTS * V_SCALE;
  localparam int PIPE_LAT = RD_LATENCY + 2;
  // The inside flag must line up with data_rd: one address stage plus the RAM latency.
  localparam int DLY      = 1 + RD_LATENCY;

  localparam logic [IDXW:0] NF_W      = (IDXW+1)'(NO_FFTS);
  localparam logic [IDXW:0] NF_LAST_W = (IDXW+1)'(NO_FFTS - 1);
  localparam logic [7:0]    SUB_LAST  = 8'(V_SCALE - 1);

  // Signed views of the coordinates. H_BIAS-1 may be negative when bias is zero.
  int sx_i;
  int sy_i;
  assign sx_i = int'(sx);
  assign sy_i = int'(sy);

  logic            frame_start;
  logic            frame_ok;
  logic [IDXW-1:0] idx_q;
  logic [IDXW-1:0] row_idx;
  logic [7:0]      sub_row;

  assign frame_start = (sx_i == 0) && (sy_i == 0);

  // ---------------- draw-box decode ----------------
  logic in_x, in_y, inside_now;
  assign in_x       = (sx_i >= H_BIAS) && (sx_i < H_BIAS + BOX_W);
  assign in_y       = (sy_i >= V_BIAS) && (sy_i < V_BIAS + BOX_H);
  assign inside_now = frame_ok && in_x && in_y;

`ifdef WATERFALL_BORDER_EN
  logic ring_x, ring_y, border_now;
  assign ring_x     = (sx_i >= H_BIAS - 1) && (sx_i <= H_BIAS + BOX_W);
  assign ring_y     = (sy_i >= V_BIAS - 1) && (sy_i <= V_BIAS + BOX_H);
  assign border_now = frame_ok && ring_x && ring_y && !(in_x && in_y);
`endif

  // ---------------- frame latch and row tracking ----------------
  always_ff @(posedge hdmi_clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q    <= '0;
      frame_ok <= 1'b0;
      row_idx  <= '0;
      sub_row  <= '0;
    end else begin
      if (frame_start) begin
        idx_q    <= oldest_fft_idx;
        frame_ok <= 1'b1;
      end
      // Counters step once per line, at column 0. This avoids dividing sy by V_SCALE.
      if (sx_i == 0) begin
        if (sy_i == V_BIAS) begin
          row_idx <= '0;
          sub_row <= '0;
        end else if ((sy_i > V_BIAS) && (sy_i < V_BIAS + BOX_H)) begin
          if (sub_row == SUB_LAST) begin
            sub_row <= '0;
            row_idx <= row_idx + 1'b1;
          end else begin
            sub_row <= sub_row + 8'd1;
          end
        end
      end
    end
  end

  // ---------------- slot / bin / address ----------------
  // row_idx never exceeds NO_FFTS-1 inside the box, so the reversed index is
  // non-negative. The sum stays below 2*NO_FFTS, so one conditional subtract wraps it.
  logic [IDXW:0]         rev_row, slot_sum, slot_w;
  logic [31:0]           slot32, bin32, addr32;
  logic [NO_BANKS-1:0]   bank_sel;

  always_comb begin
    rev_row  = NF_LAST_W - {1'b0, row_idx};
    slot_sum = {1'b0, idx_q} + rev_row;
    slot_w   = (slot_sum >= NF_W) ? (slot_sum - NF_W) : slot_sum;
    slot32   = 32'(slot_w);
    bin32    = 32'(sx_i - H_BIAS) >> H_SCALE_LOG2;
    addr32   = (slot32 / 32'(NO_BANKS)) * 32'(FFT_BINS) + bin32;
    bank_sel = NO_BANKS'(1) << (slot32 % 32'(NO_BANKS));
  end

  always_ff @(posedge hdmi_clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_rd <= '0;
      addr_rd <= '0;
    end else begin
      bank_rd <= inside_now ? bank_sel : '0;
      if (inside_now) addr_rd <= addr32[RAM_ADDR_WIDTH-1:0];
    end
  end

  // ---------------- delay lines ----------------
  logic [DLY-1:0] inside_sr;
  logic [2:0]     hve_sr [PIPE_LAT];

  always_ff @(posedge hdmi_clk or negedge reset_n) begin
    if (!reset_n) begin
      inside_sr <= '0;
      for (int i = 0; i < PIPE_LAT; i++) hve_sr[i] <= '0;
    end else begin
      inside_sr <= {inside_sr[DLY-2:0], inside_now};
      hve_sr[0] <= hve_in;
      for (int i = 1; i < PIPE_LAT; i++) hve_sr[i] <= hve_sr[i-1];
    end
  end

  assign hve = hve_sr[PIPE_LAT-1];

`ifdef WATERFALL_BORDER_EN
  logic [DLY-1:0] border_sr;
  always_ff @(posedge hdmi_clk or negedge reset_n) begin
    if (!reset_n) border_sr <= '0;
    else          border_sr <= {border_sr[DLY-2:0], border_now};
  end
`endif

  // ---------------- colour stage ----------------
  logic [7:0]  v8;
  logic [7:0]  v8x2;
  logic [23:0] cmap_rgb;
  logic [23:0] rgb_next;
  logic        de_dly;

  // The de bit one stage before the output register lines up with data_rd.
  assign de_dly = hve_sr[PIPE_LAT-2][0];

  always_comb begin
    v8 = '0;
    for (int i = 0; i < 8; i++) v8[7-i] = data_rd[DATA_WIDTH-1 - (i % DATA_WIDTH)];
    // Doubling after dropping the MSB gives 2*v8 below 128 and 2*(v8-128) above it.
    v8x2 = {v8[6:0], 1'b0};
    case (cmap_mode)
      2'd0:    cmap_rgb = {v8, 16'h0000};
      2'd2:    cmap_rgb = v8[7] ? {8'hFF, v8x2, 8'h00} : {v8x2, 8'h00, ~v8x2};
      default: cmap_rgb = {v8, v8, v8};
    endcase

    rgb_next = BG_RGB;
    if (!de_dly)                      rgb_next = 24'h000000;
`ifdef WATERFALL_BORDER_EN
    else if (border_sr[DLY-1])        rgb_next = 24'hFFFFFF;
`endif
    else if (inside_sr[DLY-1])        rgb_next = cmap_rgb;
  end

  always_ff @(posedge hdmi_clk or negedge reset_n) begin
    if (!reset_n) rgb <= '0;
    else          rgb <= rgb_next;
  end

endmodule

// File: tb/tb_waterfall_display.sv
// tb/tb_waterfall_display.sv - directed self-checking bench for waterfall_display
module tb_waterfall_display;

`ifdef WATERFALL_BORDER_EN
  localparam logic [23:0] RING_RGB = 24'hFFFFFF;
`else
  localparam logic [23:0] RING_RGB = 24'h00002D;
`endif
  localparam logic [23:0] BG = 24'h00002D;

  logic        hdmi_clk = 1'b0;
  logic        reset_n;
  logic [15:0] sx, sy;
  logic [2:0]  hve_in;
  logic [5:0]  oldest_fft_idx;
  logic [1:0]  cmap_mode;
  logic [3:0]  data_rd;

  logic [1:0]  bank_rd,  bank_rd3;
  logic [11:0] addr_rd,  addr_rd3;
  logic [23:0] rgb,      rgb3;
  logic [2:0]  hve,      hve3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 hdmi_clk = ~hdmi_clk;

  waterfall_display dut (
    .hdmi_clk(hdmi_clk), .reset_n(reset_n), .sx(sx), .sy(sy), .hve_in(hve_in),
    .oldest_fft_idx(oldest_fft_idx), .cmap_mode(cmap_mode), .data_rd(data_rd),
    .bank_rd(bank_rd), .addr_rd(addr_rd), .rgb(rgb), .hve(hve)
  );

  waterfall_display #(.RD_LATENCY(3)) dut3 (
    .hdmi_clk(hdmi_clk), .reset_n(reset_n), .sx(sx), .sy(sy), .hve_in(hve_in),
    .oldest_fft_idx(oldest_fft_idx), .cmap_mode(cmap_mode), .data_rd(data_rd),
    .bank_rd(bank_rd3), .addr_rd(addr_rd3), .rgb(rgb3), .hve(hve3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hdmi_clk);
    #1;
  endtask

  task automatic px(input int x, input int y);
    sx = 16'(x);
    sy = 16'(y);
    tick();
  endtask

  initial begin
    reset_n = 1'b0; sx = '0; sy = '0; hve_in = '0;
    oldest_fft_idx = '0; cmap_mode = 2'd0; data_rd = 4'hA;

    // Reset: outputs stay cleared while hve_in toggles.
    for (int i = 0; i < 6; i++) begin
      hve_in = 3'(i + 1);
      tick();
      check("rst_rgb", rgb, 0);
      check("rst_hve", hve, 0);
      check("rst_bank", bank_rd, 0);
      check("rst_hve3", hve3, 0);
    end
    check("rst_addr", addr_rd, 0);

    // Release reset, then measure the hve latency.
    hve_in = '0;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    hve_in = 3'b101;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) hve_in = '0;
      check($sformatf("hve_lat1_k%0d", k), hve, (k == 3) ? 3'b101 : 3'b000);
      check($sformatf("hve_lat3_k%0d", k), hve3, (k == 5) ? 3'b101 : 3'b000);
    end

    // Addressing with oldest index 10.
    hve_in = 3'b001;
    oldest_fft_idx = 6'd10;
    px(0, 0);
    px(0, 40);
    px(64, 40);
    check("addr_first_bank", bank_rd, 2'b10);
    check("addr_first_addr", addr_rd, 1024);
    check("addr_first_bank3", bank_rd3, 2'b10);
    check("addr_first_addr3", addr_rd3, 1024);
    px(575, 40);
    check("addr_last_bank", bank_rd, 2'b10);
    check("addr_last_addr", addr_rd, 1279);
    px(576, 40);
    check("addr_right_out_bank", bank_rd, 0);
    check("addr_hold", addr_rd, 1279);
    px(63, 40);
    check("addr_left_out_bank", bank_rd, 0);

    // Colormaps with data 4'hA.
    data_rd = 4'hA;
    cmap_mode = 2'd0;
    px(100, 40); px(100, 40); px(100, 40);
    check("cmap_red", rgb, 24'hAA0000);
    cmap_mode = 2'd1; tick();
    check("cmap_gray", rgb, 24'hAAAAAA);
    cmap_mode = 2'd2; tick();
    check("cmap_heat_hi", rgb, 24'hFF5400);
    cmap_mode = 2'd3; tick();
    check("cmap_gray3", rgb, 24'hAAAAAA);
    data_rd = 4'h3; cmap_mode = 2'd2; tick();
    check("cmap_heat_lo", rgb, 24'h660099);
    hve_in = 3'b000;
    tick(); tick(); tick();
    check("de_low_black", rgb, 0);
    check("de_low_hve", hve, 0);
    hve_in = 3'b001;
    px(600, 40); px(600, 40); px(600, 40);
    check("outside_bg", rgb, BG);

    // Row walk with oldest index 0.
    oldest_fft_idx = 6'd0;
    px(0, 0);
    for (int y = 40; y <= 440; y++) begin
      px(0, y);
      px(64, y);
      if (y == 40 || y == 47) begin
        check($sformatf("row_y%0d_bank", y), bank_rd, 2'b10);
        check($sformatf("row_y%0d_addr", y), addr_rd, 2048);
      end
      if (y == 48) begin
        check("row_y48_bank", bank_rd, 2'b01);
        check("row_y48_addr", addr_rd, 2048);
      end
      if (y == 439) begin
        check("row_y439_bank", bank_rd, 2'b01);
        check("row_y439_addr", addr_rd, 0);
      end
      if (y == 440) check("row_y440_bank", bank_rd, 0);
    end
    px(64, 440); px(64, 440);
    check("row_y440_bg", rgb, BG);

    // Frame latch: index changes mid-frame, takes effect next frame.
    oldest_fft_idx = 6'd10;
    px(0, 0);
    for (int y = 40; y <= 208; y++) begin
      if (y == 200) oldest_fft_idx = 6'd11;
      px(0, y);
      px(64, y);
      if (y == 200) begin
        check("latch_y200_bank", bank_rd, 2'b10);
        check("latch_y200_addr", addr_rd, 768);
      end
      if (y == 208) begin
        check("latch_y208_bank", bank_rd, 2'b01);
        check("latch_y208_addr", addr_rd, 768);
      end
    end
    px(0, 0);
    for (int y = 40; y <= 200; y++) begin
      px(0, y);
      px(64, y);
    end
    check("latch_next_bank", bank_rd, 2'b01);
    check("latch_next_addr", addr_rd, 1024);

    // rgb latency: a single inside pixel among outside pixels.
    cmap_mode = 2'd0;
    data_rd = 4'hA;
    for (int i = 0; i < 6; i++) px(600, 200);
    for (int k = 1; k <= 6; k++) begin
      px((k == 1) ? 100 : 600, 200);
      check($sformatf("rgb_lat1_k%0d", k), rgb, (k == 3) ? 24'hAA0000 : BG);
      check($sformatf("rgb_lat3_k%0d", k), rgb3, (k == 5) ? 24'hAA0000 : BG);
    end

    // Pixels in the ring just outside the box.
    for (int i = 0; i < 6; i++) px(63, 100);
    check("ring_left", rgb, RING_RGB);
    check("ring_left3", rgb3, RING_RGB);
    for (int i = 0; i < 6; i++) px(576, 100);
    check("ring_right3", rgb3, RING_RGB);
    for (int i = 0; i < 6; i++) px(200, 39);
    check("ring_top3", rgb3, RING_RGB);

    // An asynchronous reset mid-frame clears outputs without waiting for a clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_rgb", rgb, 0);
    check("async_rst_hve", hve, 0);
    check("async_rst_rgb3", rgb3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
